// File: rtl/menu_fade_ctrl.sv
// Main-menu colour path with frame-paced fade-in/fade-out.
// A palette index is registered and sent to an external palette lookup. The
// returned RGB is scaled by the brightness level that was sampled with that
// pixel, so the output is available a fixed two cycles later.
//
// state    | meaning
// ---------+--------------------------------------------------
// BLACK    | level held at 0, waiting for a fade-in request
// FADE_IN  | level rises by 1 every FRAMES_PER_STEP vsyncs
// SHOWN    | level held at 16, waiting for a fade-out request
// FADE_OUT | level falls by 1 every FRAMES_PER_STEP vsyncs
module menu_fade_ctrl #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vsync_pulse,
  input  logic       fade_in_req,
  input  logic       fade_out_req,
  input  logic       pix_valid_in,
  input  logic [3:0] index_in,
  output logic [3:0] pal_index,
  input  logic [3:0] pal_red,
  input  logic [3:0] pal_green,
  input  logic [3:0] pal_blue,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out,
  output logic       pix_valid_out,
  output logic [4:0] level,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    BLACK    = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);
  localparam logic [4:0] LVL_MAX    = 5'd16;

  state_t     state_q, state_d;
  logic [4:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [3:0] pal_index_q;
  logic       v1_q;
  logic [4:0] lvl1_q;
  logic [3:0] red_q, green_q, blue_q;
  logic       pix_valid_q;

  // fade_out_req has priority; a simultaneous fade_in_req is dropped
  logic in_req;
  assign in_req = fade_in_req & ~fade_out_req;

  // A full-brightness pixel is passed through untouched so 16 is exact
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
    logic [8:0] p;
    p = 9'(c) * 9'(l);
    if (l == LVL_MAX) return c;
    return 4'(p >> 4);
  endfunction

  // State, level, frame counter and status flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= BLACK;
      level_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: requests pre-empt a coinciding step vsync
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      BLACK: begin
        level_d = '0;
        cnt_d   = '0;
        if (in_req) state_d = FADE_IN;
      end
      FADE_IN: begin
        if (fade_out_req) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end else if (vsync_pulse) begin
          if (cnt_q >= LAST_FRAME) begin
            cnt_d   = '0;
            level_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 5'd1;
            if (level_d == LVL_MAX) begin
              state_d = SHOWN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      SHOWN: begin
        level_d = LVL_MAX;
        cnt_d   = '0;
        if (fade_out_req) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (in_req) begin
          state_d = FADE_IN;
          cnt_d   = '0;
        end else if (vsync_pulse) begin
          if (cnt_q >= LAST_FRAME) begin
            cnt_d   = '0;
            level_d = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
            if (level_d == 5'd0) begin
              state_d = BLACK;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = BLACK;
        level_d = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == FADE_IN) || (state_d == FADE_OUT);
  end

  // Stage 1: capture index, valid and the level that belongs to this pixel
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pal_index_q <= '0;
      v1_q        <= 1'b0;
      lvl1_q      <= '0;
    end else begin
      pal_index_q <= index_in;
      v1_q        <= pix_valid_in;
      lvl1_q      <= level_q;
    end
  end

  // Stage 2: scale the palette colour; blank pixels come out black
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      red_q       <= v1_q ? scale(pal_red,   lvl1_q) : 4'd0;
      green_q     <= v1_q ? scale(pal_green, lvl1_q) : 4'd0;
      blue_q      <= v1_q ? scale(pal_blue,  lvl1_q) : 4'd0;
      pix_valid_q <= v1_q;
    end
  end

  assign pal_index     = pal_index_q;
  assign red_out       = red_q;
  assign green_out     = green_q;
  assign blue_out      = blue_q;
  assign pix_valid_out = pix_valid_q;
  assign level         = level_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/menu_fade_ctrl.md
Name: menu_fade_ctrl

Overview:
- Sequences the main-menu colour path for fade-in and fade-out transitions.
- Registers each incoming pixel's 4-bit palette index and drives it to the combinational menu palette lookup.
- Scales the returned 12-bit RGB by a frame-stepped brightness level and presents the registered result to the VGA output mux.
- The game-state FSM issues fade requests; vsync paces the level steps so the level never changes mid-frame.

Parameters:
FRAMES_PER_STEP, 4, vsync pulses per brightness step (legal 1..255)

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous, active-low reset
vsync_pulse  input  1  one-cycle strobe at start of vertical blank
fade_in_req  input  1  one-cycle request: ramp brightness toward full
fade_out_req  input  1  one-cycle request: ramp brightness toward black
pix_valid_in  input  1  index_in is a visible pixel this cycle
index_in  input  4  palette index from the menu sprite ROM
pal_index  output  4  index to the palette lookup (registered)
pal_red, pal_green, pal_blue  input  4 each  combinational palette result for pal_index
red_out, green_out, blue_out  output  4 each  scaled colour
pix_valid_out  output  1  red/green/blue_out valid
level  output  5  current brightness, 0..16
busy  output  1  high in FADE_IN or FADE_OUT
done  output  1  one-cycle pulse when a fade reaches its endpoint

Behaviour:
- Reset (async, Reset_n=0):
  - state=BLACK, level=0, frame counter=0.
  - pal_index=0, rgb_out=0, pix_valid_out=0, busy=0, done=0.
- Pipeline, fixed 2-cycle latency:
  - S1 registers pal_index<=index_in, v1<=pix_valid_in, lvl1<=level.
  - S2 registers each channel as out=(pal_c*lvl1)>>4 (4b x 5b -> 9b product, take bits [7:4]), and pix_valid_out<=v1.
  - If lvl1==16, S2 outputs the channel unscaled (exact passthrough).
  - If v1==0, S2 outputs rgb 0.
  - The pipeline advances every cycle; no stall.
  - Each pixel uses the level sampled with it at S1.
- FSM states: BLACK, FADE_IN, SHOWN, FADE_OUT.
  - BLACK: level=0. fade_in_req -> FADE_IN, frame counter=0.
  - FADE_IN: on vsync_pulse, frame counter increments. When the counter reaches FRAMES_PER_STEP-1, it clears and level+=1. When level becomes 16 -> SHOWN, done=1 for one cycle.
  - SHOWN: level=16. fade_out_req -> FADE_OUT, frame counter=0.
  - FADE_OUT: mirror of FADE_IN, with level-=1. When level becomes 0 -> BLACK, done=1.
- Reversal:
  - fade_out_req in FADE_IN -> FADE_OUT from the current level, counter cleared, no done pulse.
  - fade_in_req in FADE_OUT -> FADE_IN, same rules.
- Ignored requests:
  - fade_in_req in FADE_IN or SHOWN.
  - fade_out_req in FADE_OUT or BLACK.
- Simultaneous requests: fade_out_req wins; fade_in_req is dropped.
- Request coinciding with a step vsync: the request takes effect, the step is not applied, and the counter is cleared.
- Level is saturating and never leaves 0..16.
- busy = (state==FADE_IN || state==FADE_OUT), registered alongside state.
- vsync_pulse outside fade states is ignored; the counter holds 0.
- Reset mid-fade: immediate BLACK, level 0; in-flight pipeline pixels are discarded and outputs go to 0.

Test Plan:
- Reset, then constant index with pal rgb=0xE81, pix_valid_in=1 -> rgb_out=0x000, pix_valid_out=1 two cycles after valid; level=0, busy=0.
- Level forced to 8 (fade_in_req, FRAMES_PER_STEP=1, 8 vsyncs) with rgb 0xE81 -> rgb_out=0x740; at level 16, 0xE81 -> 0xE81 exactly; 0xFFF at level 15 -> 0xEEE.
- FRAMES_PER_STEP=4, fade_in_req, 64 vsyncs -> level steps 0->16 every 4th vsync; done pulses once on the 64th; state SHOWN; busy falls the same cycle.
- FADE_IN at level 5, assert fade_in_req and fade_out_req together -> FADE_OUT; after 5*FRAMES_PER_STEP vsyncs level=0, one done pulse, BLACK.
- fade_out_req in BLACK and fade_in_req in SHOWN -> no state change, no done, level unchanged.
- Reset_n low mid-FADE_OUT at level 9 with valid pixels in flight -> same cycle: level=0, rgb_out=0, pix_valid_out=0; after release, BLACK and idle.
